reduce_acc_r: RTL and testbench
===============================

Name: reduce_acc_r

Overview:
- Parametrised, pipelined bitwise reduction engine; generalises the fixed-pattern pipelined XOR tree.
- Features: arbitrary WIDTH with padding, configurable LUT fan-in, selectable reduce operator (XOR/AND/OR), NUM_CH independent channels, valid pipeline.
- Optional multi-beat accumulation folds per-beat results across a packet delimited by din_last.
- Used by FEC/CRC/parity and alignment-check logic in the SL3 datapath wherever wide parity or all-ones/any-ones flags must close timing at full fabric rate.

Parameters:
- WIDTH, 20: bits reduced per channel per beat; any value >= 1.
- NUM_CH, 4: independent channels, each with its own tree and accumulator.
- LUT_SIZE, 6: fan-in per tree node; legal range 2..6.
- OP, 0: reduce operator. 0 = XOR, 1 = AND, 2 = OR; any other value is an elaboration error.
- ACCUM, 1: 1 = fold results across beats until din_last; 0 = one result per valid beat.
- TARGET_CHIP, 2: passed to LUT-level primitives.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- sclr  in  1  synchronous active-high reset.
- din  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- din_valid  in  1  beat qualifier.
- din_last  in  1  final beat of packet; ignored when ACCUM=0 or din_valid=0.
- dout  out  NUM_CH  reduced result, bit c belongs to channel c.
- dout_valid  out  1  one-cycle pulse, dout valid.

Behaviour:
- Tree depth LEVELS = smallest L >= 1 with LUT_SIZE^L >= WIDTH. Example: WIDTH=20, LUT_SIZE=6 gives 2; WIDTH=6 gives 1; WIDTH=37 gives 3.
- Each level groups its inputs LUT_SIZE at a time; the last group may be short.
- Padding: inputs are padded to a full group with the operator identity (0 for XOR/OR, 1 for AND). Padding never changes the result.
- Every level is registered, so the tree output is LEVELS cycles after the input edge.
- The accumulator stage adds one register. LATENCY = LEVELS+1 for both ACCUM settings: a beat accepted at edge n produces its output at edge n+LATENCY.
- The valid and last flags travel in a LATENCY-1 deep shift register alongside the tree. These are the only pipeline registers that sclr clears; tree data registers need no reset.
- ACCUM=0: dout = tree result of that beat; dout_valid = delayed din_valid.
- ACCUM=1, per channel, acc starts at identity. On each arriving valid beat:
  - next = acc OP tree result.
  - If the beat is not last: acc <= next; dout_valid stays 0.
  - If the beat is last: dout <= next, dout_valid <= 1, and acc <= identity the same cycle, so back-to-back packets need no gap.
- Single-beat packet (valid with last): result = tree result of that beat.
- Bubbles (din_valid=0) leave acc unchanged; any number of idle cycles may occur mid-packet.
- dout holds its last value between pulses; it is not cleared when dout_valid falls.
- Reset values: dout = 0, dout_valid = 0, acc = identity, valid/last pipeline = 0.
- sclr mid-packet: the partial accumulation is discarded and in-flight beats are dropped. The first valid beat after sclr deasserts starts a new packet. No dout_valid may pulse for beats accepted before or during sclr.
- sclr together with din_valid: the beat is dropped.
- Channels never interact; one common valid/last drives all channels.

Decomposition:
- Package reduce_pkg holds:
  - OP encodings: REDUCE_XOR=0, REDUCE_AND=1, REDUCE_OR=2.
  - Constant function reduce_levels(width, lut_size).
  - Function reduce_identity(op).
  - Function for the width of each level: ceil(prev/LUT_SIZE).
- Sub-module reduce_level_r: one registered tree level with parameters IN_WIDTH, LUT_SIZE, OP. It pads and reduces groups and registers NUM_OUT = ceil(IN_WIDTH/LUT_SIZE) bits.
- The top generates LEVELS instances of reduce_level_r per channel, plus the shared valid/last pipe and the per-channel accumulator.

Test Plan:
- Latency/XOR: WIDTH=20, NUM_CH=1, OP=XOR, ACCUM=0; din=20'h00001 valid at edge 0 -> dout=1, dout_valid pulse at edge 3; din=20'h00003 -> dout=0.
- Padding/AND: WIDTH=7, LUT_SIZE=6, OP=AND; din=7'h7F -> dout=1; din=7'h3F -> 0; confirms pad=1 and LEVELS=2.
- Accumulation with bubbles: OP=XOR, ACCUM=1, NUM_CH=2; beats ch0 parity 1,1,1 with idle cycles between, last on beat 3 -> single pulse, dout[0]=1; ch1 parities 1,0,0 -> dout[1]=1; no pulse on non-last beats.
- Back-to-back packets: OP=OR, ACCUM=1; packet A = one beat of zeros with last, next cycle packet B = one beat din=1 with last -> two consecutive pulses, dout=0 then 1; no carry from A to B.
- Reset mid-packet: OP=XOR, ACCUM=1; two non-last beats of parity 1, pulse sclr, then one beat of parity 0 with last -> one pulse, dout=0; no pulse during or right after sclr; after sclr dout=0, dout_valid=0.
- Wide random: WIDTH=64, NUM_CH=4, all OPs, 10k random beats with random valid/last -> matches behavioural model bit-exact at LATENCY=LEVELS+1=4.

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined reduction engine.
// Covers the operator encodings, tree-shape arithmetic and the bitwise combine rule.
package reduce_pkg;

  localparam int unsigned REDUCE_XOR = 0;
  localparam int unsigned REDUCE_AND = 1;
  localparam int unsigned REDUCE_OR  = 2;

  // Upper bound on tree depth. LUT_SIZE >= 2, so 32 levels covers any 32-bit width.
  localparam int unsigned MAX_LEVELS = 32;

  // Number of output bits a level produces from in_width inputs.
  function automatic int unsigned reduce_level_width(input int unsigned in_width,
                                                     input int unsigned lut_size);
    return (in_width + lut_size - 1) / lut_size;
  endfunction

  // Smallest depth L >= 1 with lut_size**L >= width.
  function automatic int unsigned reduce_levels(input int unsigned width,
                                                input int unsigned lut_size);
    longint unsigned span;
    int unsigned     levels;
    span   = 64'(lut_size);
    levels = 1;
    for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
      if (span < 64'(width)) begin
        span   = span * 64'(lut_size);
        levels = levels + 1;
      end
    end
    return levels;
  endfunction

  // Input width seen by tree level `level` (level 0 sees the full channel).
  function automatic int unsigned reduce_width_at(input int unsigned width,
                                                  input int unsigned lut_size,
                                                  input int unsigned level);
    int unsigned w;
    w = width;
    for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
      if (i < level) begin
        w = reduce_level_width(w, lut_size);
      end
    end
    return w;
  endfunction

  function automatic logic reduce_identity(input int unsigned op);
    return (op == REDUCE_AND);
  endfunction

  function automatic logic reduce_combine(input int unsigned op, input logic a, input logic b);
    logic r;
    case (op)
      REDUCE_AND: r = a & b;
      REDUCE_OR:  r = a | b;
      default:    r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_level_r.sv
// One registered level of the reduction tree: pads the input to whole LUT groups
// with the operator identity, reduces each group and registers one bit per group.
module reduce_level_r
  import reduce_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 20,
  parameter int unsigned LUT_SIZE    = 6,
  parameter int unsigned OP          = REDUCE_XOR,
  parameter int unsigned TARGET_CHIP = 2,
  localparam int unsigned NUM_OUT    = reduce_level_width(IN_WIDTH, LUT_SIZE)
) (
  input  logic                clk,
  input  logic [IN_WIDTH-1:0] din,
  output logic [NUM_OUT-1:0]  dout
);

  localparam int unsigned PAD_W = NUM_OUT * LUT_SIZE;
  localparam logic        IDENT = reduce_identity(OP);

  // Only the generic LUT mapping exists; reject device codes outside the known range.
  if (TARGET_CHIP > 255) begin : g_bad_chip
    $error("reduce_level_r: unsupported TARGET_CHIP");
  end

  logic [PAD_W-1:0]   padded;
  logic [NUM_OUT-1:0] dout_d;
  logic [NUM_OUT-1:0] dout_q;

  always_comb begin
    padded                 = {PAD_W{IDENT}};
    padded[IN_WIDTH-1:0]   = din;
    dout_d                 = '0;
    for (int unsigned g = 0; g < NUM_OUT; g++) begin
      dout_d[g] = IDENT;
      for (int unsigned k = 0; k < LUT_SIZE; k++) begin
        dout_d[g] = reduce_combine(OP, dout_d[g], padded[g*LUT_SIZE+k]);
      end
    end
  end

  // Data-only register; validity is tracked by the parent's flag pipe.
  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/reduce_acc_r.sv
// Multi-channel pipelined bitwise reduction (XOR/AND/OR) with an optional
// per-channel accumulator that folds beats into one result per din_last-delimited packet.
module reduce_acc_r
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LUT_SIZE    = 6,
  parameter int unsigned OP          = REDUCE_XOR,
  parameter int unsigned ACCUM       = 1,
  parameter int unsigned TARGET_CHIP = 2
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic                    din_valid,
  input  logic                    din_last,
  output logic [NUM_CH-1:0]       dout,
  output logic                    dout_valid
);

  localparam int unsigned LEVELS = reduce_levels(WIDTH, LUT_SIZE);
  localparam logic        IDENT  = reduce_identity(OP);

  if (OP > REDUCE_OR) begin : g_bad_op
    $error("reduce_acc_r: OP must be 0 (XOR), 1 (AND) or 2 (OR)");
  end
  if (LUT_SIZE < 2 || LUT_SIZE > 6) begin : g_bad_lut
    $error("reduce_acc_r: LUT_SIZE must be in 2..6");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("reduce_acc_r: WIDTH must be at least 1");
  end

  logic [NUM_CH-1:0] tree_res;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned IN_W  = reduce_width_at(WIDTH, LUT_SIZE, l);
      localparam int unsigned OUT_W = reduce_level_width(IN_W, LUT_SIZE);

      logic [IN_W-1:0]  lvl_in;
      logic [OUT_W-1:0] lvl_out;

      if (l == 0) begin : g_first
        assign lvl_in = din[c*WIDTH +: WIDTH];
      end else begin : g_next
        assign lvl_in = g_lvl[l-1].lvl_out;
      end

      reduce_level_r #(
        .IN_WIDTH    (IN_W),
        .LUT_SIZE    (LUT_SIZE),
        .OP          (OP),
        .TARGET_CHIP (TARGET_CHIP)
      ) u_level (
        .clk  (clk),
        .din  (lvl_in),
        .dout (lvl_out)
      );
    end

    // The final level always narrows to a single bit.
    assign tree_res[c] = g_lvl[LEVELS-1].lvl_out[0];
  end

  // Flag pipe runs in lockstep with the tree levels.
  logic [LEVELS-1:0] vld_d, vld_q;
  logic [LEVELS-1:0] last_d, last_q;
  logic              beat_valid;
  logic              beat_last;

  logic [NUM_CH-1:0] acc_d, acc_q;
  logic [NUM_CH-1:0] acc_next;
  logic [NUM_CH-1:0] dout_d, dout_q;
  logic              dout_valid_d, dout_valid_q;

  assign beat_valid = vld_q[LEVELS-1];
  assign beat_last  = last_q[LEVELS-1];

  always_comb begin
    vld_d  = (vld_q << 1) | LEVELS'(din_valid);
    last_d = (last_q << 1) | LEVELS'(din_valid & din_last);
  end

  always_comb begin
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    acc_next     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      acc_next[c] = reduce_combine(OP, acc_q[c], tree_res[c]);
    end
    if (ACCUM == 0) begin
      acc_d = {NUM_CH{IDENT}};
      if (beat_valid) begin
        dout_d       = tree_res;
        dout_valid_d = 1'b1;
      end
    end else if (beat_valid) begin
      if (beat_last) begin
        // Re-arm in the same cycle so the next packet can follow immediately.
        dout_d       = acc_next;
        dout_valid_d = 1'b1;
        acc_d        = {NUM_CH{IDENT}};
      end else begin
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      vld_q        <= '0;
      last_q       <= '0;
      acc_q        <= {NUM_CH{IDENT}};
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_reduce_acc_r.sv
// Self-checking bench for reduce_acc_r: directed scenarios on small configurations
// plus a randomized run of wide instances against a packet-level reference model.
module tb_reduce_acc_r;

  logic         clk = 1'b0;
  logic         sclr = 1'b1;
  logic [255:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_last = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic       lat_d, lat_v;
  logic       pad_d, pad_v;
  logic [1:0] accx_d;
  logic       accx_v;
  logic       accor_d, accor_v;
  logic       odd_d, odd_v;
  logic [3:0] wide_d [3];
  logic       wide_v [3];

  reduce_acc_r #(.WIDTH(20), .NUM_CH(1), .LUT_SIZE(6), .OP(0), .ACCUM(0), .TARGET_CHIP(2)) u_lat (
    .clk(clk), .sclr(sclr), .din(din[19:0]), .din_valid(din_valid), .din_last(din_last),
    .dout(lat_d), .dout_valid(lat_v));

  reduce_acc_r #(.WIDTH(7), .NUM_CH(1), .LUT_SIZE(6), .OP(1), .ACCUM(0), .TARGET_CHIP(2)) u_pad (
    .clk(clk), .sclr(sclr), .din(din[6:0]), .din_valid(din_valid), .din_last(din_last),
    .dout(pad_d), .dout_valid(pad_v));

  reduce_acc_r #(.WIDTH(20), .NUM_CH(2), .LUT_SIZE(6), .OP(0), .ACCUM(1), .TARGET_CHIP(2)) u_accx (
    .clk(clk), .sclr(sclr), .din(din[39:0]), .din_valid(din_valid), .din_last(din_last),
    .dout(accx_d), .dout_valid(accx_v));

  reduce_acc_r #(.WIDTH(20), .NUM_CH(1), .LUT_SIZE(6), .OP(2), .ACCUM(1), .TARGET_CHIP(2)) u_accor (
    .clk(clk), .sclr(sclr), .din(din[19:0]), .din_valid(din_valid), .din_last(din_last),
    .dout(accor_d), .dout_valid(accor_v));

  reduce_acc_r #(.WIDTH(37), .NUM_CH(1), .LUT_SIZE(3), .OP(0), .ACCUM(0), .TARGET_CHIP(2)) u_odd (
    .clk(clk), .sclr(sclr), .din(din[36:0]), .din_valid(din_valid), .din_last(din_last),
    .dout(odd_d), .dout_valid(odd_v));

  for (genvar g = 0; g < 3; g++) begin : g_wide
    reduce_acc_r #(.WIDTH(64), .NUM_CH(4), .LUT_SIZE(6), .OP(g), .ACCUM(1), .TARGET_CHIP(2)) u_dut (
      .clk(clk), .sclr(sclr), .din(din), .din_valid(din_valid), .din_last(din_last),
      .dout(wide_d[g]), .dout_valid(wide_v[g]));
  end

  function automatic logic ref_reduce(input int op, input logic [63:0] v);
    logic r;
    case (op)
      0:       r = ^v;
      1:       r = &v;
      default: r = |v;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    sclr      = 1'b1;
    din_valid = 1'b0;
    din_last  = 1'b0;
    din       = '0;
    tick();
    tick();
    sclr = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++; if (lat_v !== 1'b0 || lat_d !== 1'b0) begin
      n_fail++; $display("FAIL reset_lat: got v=%b d=%b, expected 0/0", lat_v, lat_d);
    end
    n_tests++; if (pad_v !== 1'b0 || pad_d !== 1'b0) begin
      n_fail++; $display("FAIL reset_pad: got v=%b d=%b, expected 0/0", pad_v, pad_d);
    end
    n_tests++; if (accx_v !== 1'b0 || accx_d !== 2'b00) begin
      n_fail++; $display("FAIL reset_accx: got v=%b d=%b, expected 0/00", accx_v, accx_d);
    end
    n_tests++; if (accor_v !== 1'b0 || accor_d !== 1'b0) begin
      n_fail++; $display("FAIL reset_accor: got v=%b d=%b, expected 0/0", accor_v, accor_d);
    end
    for (int g = 0; g < 3; g++) begin
      n_tests++; if (wide_v[g] !== 1'b0 || wide_d[g] !== 4'h0) begin
        n_fail++; $display("FAIL reset_wide%0d: got v=%b d=%h, expected 0/0", g, wide_v[g], wide_d[g]);
      end
    end
  endtask

  task automatic test_latency_xor;
    logic [19:0] pats [2];
    logic        exps [2];
    pats[0] = 20'h00001; exps[0] = 1'b1;
    pats[1] = 20'h00003; exps[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      din[19:0] = pats[p];
      din_valid = 1'b1;
      for (int t = 1; t <= 5; t++) begin
        tick();
        din_valid = 1'b0;
        n_tests++; if (lat_v !== (t == 3)) begin
          n_fail++; $display("FAIL latency_xor_valid p%0d t%0d: got %b expected %b", p, t, lat_v, t == 3);
        end
        if (t >= 3) begin
          n_tests++; if (lat_d !== exps[p]) begin
            n_fail++; $display("FAIL latency_xor_dout p%0d t%0d: got %b expected %b", p, t, lat_d, exps[p]);
          end
        end
      end
    end
  endtask

  task automatic test_padding_and;
    logic [6:0] pats [3];
    logic       exps [3];
    pats[0] = 7'h7F; exps[0] = 1'b1;
    pats[1] = 7'h3F; exps[1] = 1'b0;
    pats[2] = 7'h7E; exps[2] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      do_reset();
      din[6:0]  = pats[p];
      din_valid = 1'b1;
      for (int t = 1; t <= 3; t++) begin
        tick();
        din_valid = 1'b0;
      end
      n_tests++; if (pad_v !== 1'b1 || pad_d !== exps[p]) begin
        n_fail++; $display("FAIL padding_and p%0d: got v=%b d=%b expected v=1 d=%b", p, pad_v, pad_d, exps[p]);
      end
    end
  endtask

  task automatic test_accum_bubbles;
    do_reset();
    for (int t = 0; t < 15; t++) begin
      din_valid = (t == 0 || t == 3 || t == 7);
      din_last  = (t == 7);
      din[19:0]  = 20'h00001;
      din[39:20] = (t == 0) ? 20'h00001 : 20'h00003;
      tick();
      n_tests++; if (accx_v !== (t == 9)) begin
        n_fail++; $display("FAIL accum_bubbles_valid t%0d: got %b expected %b", t, accx_v, t == 9);
      end
      if (t == 9) begin
        n_tests++; if (accx_d !== 2'b11) begin
          n_fail++; $display("FAIL accum_bubbles_dout: got %b expected 11", accx_d);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int t = 0; t < 7; t++) begin
      din_valid = (t < 2);
      din_last  = (t < 2);
      din[19:0] = (t == 1) ? 20'h00001 : 20'h00000;
      tick();
      n_tests++; if (accor_v !== (t == 2 || t == 3)) begin
        n_fail++; $display("FAIL back_to_back_valid t%0d: got %b expected %b", t, accor_v, t == 2 || t == 3);
      end
      if (t == 2 || t == 3) begin
        n_tests++; if (accor_d !== (t == 3)) begin
          n_fail++; $display("FAIL back_to_back_dout t%0d: got %b expected %b", t, accor_d, t == 3);
        end
      end
    end
  endtask

  task automatic test_sclr_mid;
    do_reset();
    for (int t = 0; t < 11; t++) begin
      sclr       = (t == 2);
      din_valid  = (t <= 2 || t == 4);
      din_last   = (t == 2 || t == 4);
      din[19:0]  = (t == 4) ? 20'h00003 : 20'h00001;
      din[39:20] = (t == 1) ? 20'h00001 : 20'h00000;
      tick();
      if (t == 2) begin
        n_tests++; if (accx_v !== 1'b0 || accx_d !== 2'b00) begin
          n_fail++; $display("FAIL sclr_mid_after_reset: got v=%b d=%b expected 0/00", accx_v, accx_d);
        end
      end
      n_tests++; if (accx_v !== (t == 6)) begin
        n_fail++; $display("FAIL sclr_mid_valid t%0d: got %b expected %b", t, accx_v, t == 6);
      end
      if (t == 6) begin
        n_tests++; if (accx_d !== 2'b00) begin
          n_fail++; $display("FAIL sclr_mid_dout: got %b expected 00", accx_d);
        end
      end
    end
    sclr = 1'b0;
  endtask

  // Expected-output slots indexed by cycle modulo 8 (all latencies are below 8).
  logic       ev    [4][8];
  logic [3:0] ed    [4][8];
  logic [3:0] mdout [4];
  logic [3:0] macc  [3];

  task automatic test_random;
    int         lat [4];
    int         slot;
    logic       obs_v;
    logic [3:0] obs_d;
    logic [3:0] exp_d;
    logic       r;
    logic       nxt;
    lat[0] = 4; lat[1] = 4; lat[2] = 4; lat[3] = 5;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mdout[i] = 4'h0;
      for (int s = 0; s < 8; s++) begin
        ev[i][s] = 1'b0;
        ed[i][s] = 4'h0;
      end
    end
    for (int op = 0; op < 3; op++) macc[op] = (op == 1) ? 4'hF : 4'h0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      slot = cyc % 8;
      for (int i = 0; i < 4; i++) begin
        if (i < 3) begin
          obs_v = wide_v[i];
          obs_d = wide_d[i];
        end else begin
          obs_v = odd_v;
          obs_d = {3'b000, odd_d};
        end
        exp_d = ev[i][slot] ? ed[i][slot] : mdout[i];
        n_tests++;
        if (obs_v !== ev[i][slot] || obs_d !== exp_d) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: got v=%b d=%h expected v=%b d=%h",
                   i, cyc, obs_v, obs_d, ev[i][slot], exp_d);
        end
        mdout[i]    = exp_d;
        ev[i][slot] = 1'b0;
      end

      for (int w = 0; w < 8; w++) din[w*32 +: 32] = $urandom();
      din_valid = ($urandom_range(0, 9) < 7);
      din_last  = ($urandom_range(0, 3) == 0);
      sclr      = ($urandom_range(0, 199) == 0);

      if (sclr) begin
        for (int i = 0; i < 4; i++) begin
          mdout[i] = 4'h0;
          for (int s = 0; s < 8; s++) ev[i][s] = 1'b0;
        end
        for (int op = 0; op < 3; op++) macc[op] = (op == 1) ? 4'hF : 4'h0;
      end else if (din_valid) begin
        for (int op = 0; op < 3; op++) begin
          for (int ch = 0; ch < 4; ch++) begin
            r = ref_reduce(op, din[ch*64 +: 64]);
            case (op)
              0:       nxt = macc[op][ch] ^ r;
              1:       nxt = macc[op][ch] & r;
              default: nxt = macc[op][ch] | r;
            endcase
            if (din_last) begin
              ed[op][(cyc + lat[op]) % 8][ch] = nxt;
              macc[op][ch] = (op == 1);
            end else begin
              macc[op][ch] = nxt;
            end
          end
          if (din_last) ev[op][(cyc + lat[op]) % 8] = 1'b1;
        end
        ev[3][(cyc + lat[3]) % 8] = 1'b1;
        ed[3][(cyc + lat[3]) % 8] = {3'b000, ^din[36:0]};
      end
      tick();
    end
    sclr      = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency_xor();
    test_padding_and();
    test_accum_bubbles();
    test_back_to_back();
    test_sclr_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
